// File: rtl/seq_mod_pkg.sv
// Shared definitions for the sequential modulus/quotient unit: FSM state
// encodings and the quotient bit pattern reported on divide-by-zero.
package seq_mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Replicated to the operand width: a divide-by-zero quotient is all ones.
  localparam logic DBZ_Q_BIT = 1'b1;

endpackage

// File: rtl/mod_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor if it fits and report the resulting quotient bit.
module mod_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted partial remainder can momentarily need one extra bit.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem, dvd_bit};
    if (shifted >= {1'b0, den}) begin
      rem_next = WIDTH'(shifted - {1'b0, den});
      q_bit    = 1'b1;
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_modulus_unit.sv
// Multi-cycle restoring divider with start/done handshake, one quotient bit
// per clock. Define SIGNED_MOD_EN for two's-complement operands.
module seq_modulus_unit
  import seq_mod_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] quotient,
  output logic             error
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] modulus_q, modulus_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;
  logic [WIDTH-1:0] quo_raw;
  logic [WIDTH-1:0] num_mag, den_mag;
  logic [WIDTH-1:0] rem_final, quo_final;

  mod_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .den      (den_q),
    .rem_next (step_rem),
    .q_bit    (step_q_bit)
  );

  // Quotient bits shift into the dividend register as dividend bits leave it.
  assign quo_raw = {dvd_q[WIDTH-2:0], step_q_bit};

`ifdef SIGNED_MOD_EN
  logic neg_rem_q, neg_rem_d;
  logic neg_quo_q, neg_quo_d;

  assign num_mag   = numerator[WIDTH-1]   ? -numerator   : numerator;
  assign den_mag   = denominator[WIDTH-1] ? -denominator : denominator;
  assign rem_final = neg_rem_q ? -step_rem : step_rem;
  assign quo_final = neg_quo_q ? -quo_raw  : quo_raw;
`else
  assign num_mag   = numerator;
  assign den_mag   = denominator;
  assign rem_final = step_rem;
  assign quo_final = quo_raw;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    den_d      = den_q;
    modulus_d  = modulus_q;
    quotient_d = quotient_q;
    error_d    = error_q;
`ifdef SIGNED_MOD_EN
    neg_rem_d  = neg_rem_q;
    neg_quo_d  = neg_quo_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start) begin
          if (denominator == '0) begin
            state_d    = ST_DONE;
            modulus_d  = numerator;
            quotient_d = {WIDTH{DBZ_Q_BIT}};
            error_d    = 1'b1;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(WIDTH);
            rem_d   = '0;
            dvd_d   = num_mag;
            den_d   = den_mag;
            error_d = 1'b0;
`ifdef SIGNED_MOD_EN
            neg_rem_d = numerator[WIDTH-1];
            neg_quo_d = numerator[WIDTH-1] ^ denominator[WIDTH-1];
`endif
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        dvd_d = quo_raw;
        cnt_d = cnt_q - CNT_W'(1);
        // Last iteration: results (with sign fix-up) land on the DONE-entry edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_DONE;
          modulus_d  = rem_final;
          quotient_d = quo_final;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      den_q      <= '0;
      modulus_q  <= '0;
      quotient_q <= '0;
      error_q    <= 1'b0;
`ifdef SIGNED_MOD_EN
      neg_rem_q  <= 1'b0;
      neg_quo_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      den_q      <= den_d;
      modulus_q  <= modulus_d;
      quotient_q <= quotient_d;
      error_q    <= error_d;
`ifdef SIGNED_MOD_EN
      neg_rem_q  <= neg_rem_d;
      neg_quo_q  <= neg_quo_d;
`endif
    end
  end

  assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy     = (state_q == ST_CALC);
  assign done     = (state_q == ST_DONE);
  assign modulus  = modulus_q;
  assign quotient = quotient_q;
  assign error    = error_q;

endmodule

// File: tb/tb_seq_modulus_unit.sv
// Directed self-checking bench for seq_modulus_unit (WIDTH=16); the signed
// vectors run only when SIGNED_MOD_EN is defined.
module tb_seq_modulus_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] numerator;
  logic [15:0] denominator;
  logic        ready, busy, done, error;
  logic [15:0] modulus, quotient;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, busy_cnt, done_cnt;

  seq_modulus_unit #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .numerator   (numerator),
    .denominator (denominator),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .modulus     (modulus),
    .quotient    (quotient),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; returns #1 after that edge.
  task automatic launch(input logic [15:0] n, input logic [15:0] d);
    @(negedge clk);
    numerator   = n;
    denominator = d;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from the start edge (cycle 1 = just after it) until done.
  task automatic wait_done(output int cycles, output int busy_seen);
    cycles    = 1;
    busy_seen = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_seen++;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) cycles = -1;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    numerator   = '0;
    denominator = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    ready,    1);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_modulus",  modulus,  0);
    check("rst_quotient", quotient, 0);
    check("rst_error",    error,    0);
    @(negedge clk);
    reset = 1'b0;

    // 15 % 2
    launch(16'd15, 16'd2);
    check("t1_busy_after_start", busy, 1);
    wait_done(lat, busy_cnt);
    check("t1_latency",  lat,      17);
    check("t1_busy_cnt", busy_cnt, 16);
    check("t1_modulus",  modulus,  1);
    check("t1_quotient", quotient, 7);
    check("t1_error",    error,    0);
    check("t1_ready",    ready,    1);
    @(posedge clk); #1;
    check("t1_done_pulse", done,  0);
    check("t1_idle_ready", ready, 1);

    // 0xFFFF % 0
    launch(16'hFFFF, 16'h0000);
    wait_done(lat, busy_cnt);
    check("t2_latency",  lat,      1);
    check("t2_error",    error,    1);
    check("t2_modulus",  modulus,  16'hFFFF);
    check("t2_quotient", quotient, 16'hFFFF);

    // 1000 % 7 with an ignored start mid-CALC
    launch(16'd1000, 16'd7);
    check("t3_error_cleared", error,   0);
    check("t3_results_held",  modulus, 16'hFFFF);
    repeat (4) begin @(posedge clk); #1; end
    numerator   = 16'd5;
    denominator = 16'd3;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t3_still_busy", busy,  1);
    check("t3_not_ready",  ready, 0);
    wait_done(lat, busy_cnt);
    check("t3_done_seen", (lat > 0), 1);
    check("t3_modulus",  modulus,  6);
    check("t3_quotient", quotient, 142);

    // reset in CALC cycle 8, with a start in the same cycle
    launch(16'd100, 16'd3);
    repeat (7) begin @(posedge clk); #1; end
    @(negedge clk);
    reset       = 1'b1;
    start       = 1'b1;
    numerator   = 16'd7;
    denominator = 16'd0;
    @(posedge clk); #1;
    check("t4_modulus",  modulus,  0);
    check("t4_quotient", quotient, 0);
    check("t4_ready",    ready,    1);
    check("t4_busy",     busy,     0);
    check("t4_done",     done,     0);
    check("t4_error",    error,    0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("t4_no_done", done_cnt, 0);

    // Back-to-back: start held in the DONE cycle
    launch(16'd40000, 16'd300);
    wait_done(lat, busy_cnt);
    check("t5a_latency",  lat,      17);
    check("t5a_modulus",  modulus,  100);
    check("t5a_quotient", quotient, 133);
    numerator   = 16'd9;
    denominator = 16'd4;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5b_busy",      busy,    1);
    check("t5b_done_low",  done,    0);
    check("t5b_held_mod",  modulus, 100);
    wait_done(lat, busy_cnt);
    check("t5b_latency",  lat,      17);
    check("t5b_modulus",  modulus,  1);
    check("t5b_quotient", quotient, 2);

    // Boundaries: numerator < denominator, zero numerator, divide by one
    launch(16'd3, 16'd10);
    wait_done(lat, busy_cnt);
    check("t6_small_mod", modulus,  3);
    check("t6_small_quo", quotient, 0);
    launch(16'd0, 16'd5);
    wait_done(lat, busy_cnt);
    check("t6_zero_mod", modulus,  0);
    check("t6_zero_quo", quotient, 0);
    launch(16'hFFFF, 16'd1);
    wait_done(lat, busy_cnt);
    check("t6_div1_mod", modulus,  0);
    check("t6_div1_quo", quotient, 16'hFFFF);

`ifdef SIGNED_MOD_EN
    launch(16'hFFF9, 16'd2);
    wait_done(lat, busy_cnt);
    check("s_latency",    lat,      17);
    check("s_neg7_mod",   modulus,  16'hFFFF);
    check("s_neg7_quo",   quotient, 16'hFFFD);
    launch(16'd7, 16'hFFFE);
    wait_done(lat, busy_cnt);
    check("s_7_neg2_mod", modulus,  1);
    check("s_7_neg2_quo", quotient, 16'hFFFD);
    launch(16'h8000, 16'hFFFF);
    wait_done(lat, busy_cnt);
    check("s_min_mod",    modulus,  0);
    check("s_min_quo",    quotient, 16'h8000);
    check("s_min_err",    error,    0);
    launch(16'hFFF9, 16'h0000);
    wait_done(lat, busy_cnt);
    check("s_dbz_err",    error,    1);
    check("s_dbz_mod",    modulus,  16'hFFF9);
    check("s_dbz_quo",    quotient, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
